pattern_bit_serializer: RTL and testbench

Upstream feeder for the serial pattern detector. It accepts WIDTH-bit words on a valid/ready handshake and emits them as a one-bit-per-clock stream on valid_o/data_o, which wire directly to the detector's valid_i/data_i. It supports back-to-back words without bubbles, a stall input that inserts gaps (valid_o low), and a last-bit marker for word-aligned checking.

---
 rtl/pattern_bit_serializer.sv | 84 ++++++++
 tb/tb_pattern_bit_serializer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pattern_bit_serializer.sv
// pattern_bit_serializer: turns WIDTH-bit words from a valid/ready source into
// a one-bit-per-clock stream (valid_o/data_o/last_o) for the pattern detector.
// The word in flight lives in a shift register; a remaining-bit counter doubles
// as the state: cnt==0 is idle, cnt!=0 is shifting.
module pattern_bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             in_ready_o,
  input  logic             hold_i,
  output logic             valid_o,
  output logic             data_o,
  output logic             last_o,
  output logic             busy_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_shifted;
  logic [CW-1:0]    cnt;
  logic             cnt_is_one;
  logic             load;
  logic             emit;
  logic             next_bit;

  assign busy_o     = (cnt != '0);
  assign cnt_is_one = (cnt == CW'(1));

  // Ready when idle, or when the edge about to happen emits the final bit,
  // so a following word streams without a bubble.
  assign in_ready_o = !busy_o | (cnt_is_one & !hold_i);
  assign load       = in_valid_i & in_ready_o;
  assign emit       = busy_o & !hold_i;

  // Select the outgoing bit and the register image after shifting it out.
  always_comb begin
    next_bit     = 1'b0;
    sreg_shifted = '0;
    if (MSB_FIRST) begin
      next_bit     = sreg[WIDTH-1];
      sreg_shifted = {sreg[WIDTH-2:0], 1'b0};
    end else begin
      next_bit     = sreg[0];
      sreg_shifted = {1'b0, sreg[WIDTH-1:1]};
    end
  end

  // Output registers: a stream bit appears only on edges that emit.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_o <= 1'b0;
      data_o  <= 1'b0;
      last_o  <= 1'b0;
    end else if (emit) begin
      valid_o <= 1'b1;
      data_o  <= next_bit;
      last_o  <= cnt_is_one;
    end else begin
      valid_o <= 1'b0;
      last_o  <= 1'b0;
    end
  end

  // Shift register and counter: a load takes priority over the decrement
  // of the same edge (the last bit of the old word still leaves via data_o).
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sreg <= in_data_i;
      cnt  <= CW'(WIDTH);
    end else if (emit) begin
      sreg <= sreg_shifted;
      cnt  <= cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_pattern_bit_serializer.sv
// Scoreboard bench for pattern_bit_serializer. Two instances (MSB-first and
// LSB-first) share all inputs; accepted words are expanded into expected bit
// sequences for each order, and a monitor pops and compares them whenever a
// DUT presents a valid bit.
module tb_pattern_bit_serializer;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_i = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         hold = 1'b0;

  logic rdy_m, valid_m, data_m, last_m, busy_m;
  logic rdy_l, valid_l, data_l, last_l, busy_l;

  pattern_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(rdy_m), .hold_i(hold), .valid_o(valid_m), .data_o(data_m),
    .last_o(last_m), .busy_o(busy_m)
  );

  pattern_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(rdy_l), .hold_i(hold), .valid_o(valid_l), .data_o(data_l),
    .last_o(last_l), .busy_o(busy_l)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: number of bits still owed, whether a bit is due this cycle,
  // and per-order queues of {last, bit}.
  int         rem = 0;
  logic       exp_valid = 1'b0;
  logic [1:0] q_m[$];
  logic [1:0] q_l[$];
  logic       mon_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word is taken when the source offers it while nothing
  // or only the bit leaving on this edge remains; a bit leaves on every edge
  // with work outstanding and no stall.
  always @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      rem = 0;
      exp_valid = 1'b0;
      q_m.delete();
      q_l.delete();
    end else begin
      logic em, acc;
      em  = (rem != 0) && !hold;
      acc = in_valid && ((rem == 0) || (rem == 1 && !hold));
      exp_valid = em;
      if (acc) begin
        for (int i = 0; i < W; i++) begin
          q_m.push_back({(i == W - 1) ? 1'b1 : 1'b0, in_data[W-1-i]});
          q_l.push_back({(i == W - 1) ? 1'b1 : 1'b0, in_data[i]});
        end
        rem = W;
      end else if (em) begin
        rem = rem - 1;
      end
    end
  end

  // Monitor: compare the stream away from the active edge.
  always @(negedge clk) begin
    if (mon_on) begin
      logic [1:0] e;
      check("valid_msb", valid_m, exp_valid);
      check("valid_lsb", valid_l, exp_valid);
      check("busy_msb", busy_m, rem != 0);
      check("busy_lsb", busy_l, rem != 0);
      if (valid_m) begin
        if (q_m.size() == 0) check("underflow_msb", 1, 0);
        else begin
          e = q_m.pop_front();
          check("data_msb", data_m, e[0]);
          check("last_msb", last_m, e[1]);
        end
      end else check("last_idle_msb", last_m, 0);
      if (valid_l) begin
        if (q_l.size() == 0) check("underflow_lsb", 1, 0);
        else begin
          e = q_l.pop_front();
          check("data_lsb", data_l, e[0]);
          check("last_lsb", last_l, e[1]);
        end
      end else check("last_idle_lsb", last_l, 0);
    end
  end

  // One cycle of stimulus, called at a falling edge; reports acceptance.
  task automatic step(input logic v, input logic [W-1:0] d, input logic h, output logic acc);
    logic exp_rdy;
    in_valid = v;
    in_data  = d;
    hold     = h;
    #1;
    exp_rdy = (rem == 0) || (rem == 1 && !h);
    check("ready_msb", rdy_m, exp_rdy);
    check("ready_lsb", rdy_l, exp_rdy);
    acc = v && exp_rdy;
    @(negedge clk);
  endtask

  // Offer a word until accepted; hold_pct is the stall probability per cycle.
  task automatic send(input logic [W-1:0] d, input int hold_pct);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      step(1'b1, d, ($urandom_range(99) < hold_pct) ? 1'b1 : 1'b0, acc);
      n++;
    end
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, acc);
  endtask

  task automatic drain();
    int n;
    logic acc;
    n = 0;
    while ((rem != 0 || exp_valid) && n < 200) begin
      step(1'b0, '0, 1'b0, acc);
      n++;
    end
    if (rem != 0) check("drain_timeout", 0, 1);
    idle(2);
    check("queue_empty_msb", q_m.size(), 0);
    check("queue_empty_lsb", q_l.size(), 0);
  endtask

  initial begin
    logic acc;
    // Reset state.
    #2;
    check("rst_valid", valid_m, 0);
    check("rst_busy", busy_m, 0);
    check("rst_last", last_m, 0);
    check("rst_ready", rdy_m, 1);
    @(negedge clk);
    rst_i = 1'b1;
    mon_on = 1'b1;
    idle(2);

    // Single word, then back-to-back FF/00, then a 3-cycle stall after bit 2.
    send(8'hB4, 0);
    drain();
    send(8'hFF, 0);
    send(8'h00, 0);
    drain();
    step(1'b1, 8'hB4, 1'b0, acc);
    if (!acc) check("accept_b4", 0, 1);
    step(1'b0, '0, 1'b0, acc);
    step(1'b0, '0, 1'b0, acc);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, acc);
    drain();
    send(8'h01, 0);
    drain();

    // Load together with a stall while idle: first bit waits for hold low.
    step(1'b1, 8'h96, 1'b1, acc);
    if (!acc) check("accept_hold_idle", 0, 1);
    step(1'b0, '0, 1'b1, acc);
    drain();

    // Asynchronous reset after 4 bits, mid-cycle.
    send(8'hB4, 0);
    idle(4);
    #2;
    rst_i = 1'b0;
    #1;
    check("arst_valid", valid_m, 0);
    check("arst_busy", busy_m, 0);
    check("arst_last", last_m, 0);
    check("arst_ready", rdy_m, 1);
    check("arst_valid_lsb", valid_l, 0);
    #1;
    rst_i = 1'b1;
    @(negedge clk);
    send(8'h5A, 0);
    drain();

    // Word offered while busy waits for the last-bit cycle.
    send(8'hB4, 0);
    idle(3);
    send(8'hC3, 0);
    drain();

    // Randomised traffic with stalls and idle gaps.
    for (int k = 0; k < 60; k++) begin
      send(W'($urandom), 25);
      if ($urandom_range(3) == 0) idle($urandom_range(3));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
